// File: rtl/rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// rst_seq_pkg
// Shared types and width helpers for the reset sequencer (rst_seq_gen).
//   seq_state_e : sequencer FSM states (HOLD -> RELEASE -> DONE)
//   cnt_width() : width of the shared hold/gap counter
//   idx_width() : width of the channel index (never below 1 bit)
// ---------------------------------------------------------------------------
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } seq_state_e;

    // The counter serves both the hold window (0..min_assert-1) and the
    // per-channel gaps (0..2**dly_w-1), so it takes the wider of the two.
    function automatic int cnt_width(input int dly_w, input int min_assert);
        int w;
        w = (min_assert > 1) ? $clog2(min_assert) : 1;
        return (dly_w > w) ? dly_w : w;
    endfunction

    function automatic int idx_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// ---------------------------------------------------------------------------
// rst_sync
// Asynchronous-assert / synchronous-deassert reset bridge. Reusable.
//   clk        : destination clock
//   arst_n     : raw asynchronous active-low reset
//   rst_sync_n : active-low reset, drops immediately with arst_n and rises
//                STAGES rising edges after arst_n is released
// ---------------------------------------------------------------------------
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic arst_n,
    output logic rst_sync_n
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_reg[STAGES-1];

endmodule

// File: rtl/rst_seq_gen.sv
// ---------------------------------------------------------------------------
// rst_seq_gen
// Reset sequencer and clock-enable generator. Holds all channel resets for
// MIN_ASSERT cycles after any reset source clears, then releases channels
// 0..NUM_CH-1 in order, channel k following dly[k]+1 cycles after its
// predecessor. A free-running divider produces a single-cycle tick.
//   clk        : clock, rising edge
//   reset      : asynchronous active-low board reset
//   sw_rst_req : synchronous level-sensitive soft-reset request
//   ch_dly_i   : per-channel release gap, slice [k*DLY_W +: DLY_W]
//   div_i      : tick period minus one
//   ch_rst_n_o : active-low channel resets (bit k = channel k)
//   seq_done_o : all channels released
//   busy_o     : sequence not complete
//   tick_o     : single-cycle clock enable
// ---------------------------------------------------------------------------
module rst_seq_gen #(
    parameter int NUM_CH      = 4,
    parameter int DLY_W       = 8,
    parameter int MIN_ASSERT  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sw_rst_req,
    input  logic [NUM_CH*DLY_W-1:0] ch_dly_i,
    input  logic [DIV_W-1:0]        div_i,
    output logic [NUM_CH-1:0]       ch_rst_n_o,
    output logic                    seq_done_o,
    output logic                    busy_o,
    output logic                    tick_o
);

    import rst_seq_pkg::*;

    localparam int CNT_W = cnt_width(DLY_W, MIN_ASSERT);
    localparam int IDX_W = idx_width(NUM_CH);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_ASSERT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

    logic             rst_sync_n;
    seq_state_e       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             done_reg;
    logic             busy_reg;
    logic [DIV_W-1:0] tcnt_reg;
    logic [DIV_W-1:0] div_q_reg;
    logic             tick_reg;

    logic             hold_clear;
    logic             hold_last;
    logic             rel_hit;
    logic [DLY_W-1:0] dly_q [NUM_CH];
    logic [DLY_W-1:0] dly_cur;

    rst_sync #(
        .STAGES     (SYNC_STAGES)
    ) u_rst_sync (
        .clk        (clk),
        .arst_n     (reset),
        .rst_sync_n (rst_sync_n)
    );

    // Both the synchronised board reset and the soft request force the
    // sequencer back to the start of HOLD; the soft request therefore wins
    // over any release or DONE entry that would happen on the same edge.
    assign hold_clear = !rst_sync_n || sw_rst_req;
    assign hold_last  = (state_reg == HOLD) && (cnt_reg == HOLD_LAST);
    assign dly_cur    = dly_q[idx_reg];
    assign rel_hit    = (state_reg == RELEASE) && (cnt_reg == CNT_W'(dly_cur));

    // Per-channel gap snapshot and release flag. The snapshot is taken on
    // the HOLD->RELEASE edge so gap edits mid-sequence apply to the next run.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DLY_W-1:0] dly_reg;
            logic             rel_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    dly_reg <= '0;
                    rel_reg <= 1'b0;
                end else if (hold_clear) begin
                    rel_reg <= 1'b0;
                end else begin
                    if (hold_last) begin
                        dly_reg <= ch_dly_i[gi*DLY_W +: DLY_W];
                    end
                    if (rel_hit && (idx_reg == IDX_W'(gi))) begin
                        rel_reg <= 1'b1;
                    end
                end
            end

            assign dly_q[gi]      = dly_reg;
            assign ch_rst_n_o[gi] = rel_reg;
        end
    endgenerate

    // Sequencer FSM. cnt is cleared on every state change and on every
    // release match, so it never needs to wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= HOLD;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b1;
        end else if (hold_clear) begin
            state_reg <= HOLD;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b1;
        end else begin
            case (state_reg)
                HOLD: begin
                    if (hold_last) begin
                        state_reg <= RELEASE;
                        cnt_reg   <= '0;
                        idx_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RELEASE: begin
                    if (rel_hit) begin
                        cnt_reg <= '0;
                        if (idx_reg == IDX_LAST) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= DONE;
                end
                default: begin
                    state_reg <= HOLD;
                    cnt_reg   <= '0;
                    idx_reg   <= '0;
                end
            endcase
        end
    end

    // Tick divider. div_q keeps loading while the synchroniser holds, which
    // captures div_i at reset exit, and reloads on every wrap so a new
    // period only takes effect once the current one has finished. The tick
    // flop is set on the wrap edge, so it is high for one cycle per period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt_reg  <= '0;
            div_q_reg <= '0;
            tick_reg  <= 1'b0;
        end else if (!rst_sync_n) begin
            tcnt_reg  <= '0;
            div_q_reg <= div_i;
            tick_reg  <= 1'b0;
        end else if (tcnt_reg == div_q_reg) begin
            tcnt_reg  <= '0;
            div_q_reg <= div_i;
            tick_reg  <= 1'b1;
        end else begin
            tcnt_reg  <= tcnt_reg + 1'b1;
            tick_reg  <= 1'b0;
        end
    end

    assign seq_done_o = done_reg;
    assign busy_o     = busy_reg;
    assign tick_o     = tick_reg;

endmodule

// File: tb/tb_rst_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_rst_seq_gen
// Self-checking bench for rst_seq_gen. A timeline model (release cycle
// numbers and next-tick cycle numbers computed from the programmed gaps and
// divider) predicts every output in every cycle; table vectors and short
// hand-written sequences add checks against hand-derived release cycles.
// ---------------------------------------------------------------------------
module tb_rst_seq_gen;

    localparam int NUM_CH      = 4;
    localparam int DLY_W       = 8;
    localparam int MIN_ASSERT  = 16;
    localparam int SYNC_STAGES = 2;
    localparam int DIV_W       = 8;

    localparam logic [NUM_CH*DLY_W-1:0] T1_DLY  = {8'd1, 8'd5, 8'd0, 8'd2};
    localparam logic [NUM_CH*DLY_W-1:0] MAX_DLY = {8'd255, 8'd255, 8'd255, 8'd255};

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    sw_rst_req = 1'b0;
    logic [NUM_CH*DLY_W-1:0] ch_dly_i = '0;
    logic [DIV_W-1:0]        div_i = '0;
    logic [NUM_CH-1:0]       ch_rst_n_o;
    logic                    seq_done_o;
    logic                    busy_o;
    logic                    tick_o;

    rst_seq_gen #(
        .NUM_CH      (NUM_CH),
        .DLY_W       (DLY_W),
        .MIN_ASSERT  (MIN_ASSERT),
        .SYNC_STAGES (SYNC_STAGES),
        .DIV_W       (DIV_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_rst_req (sw_rst_req),
        .ch_dly_i   (ch_dly_i),
        .div_i      (div_i),
        .ch_rst_n_o (ch_rst_n_o),
        .seq_done_o (seq_done_o),
        .busy_o     (busy_o),
        .tick_o     (tick_o)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    // Timeline model state
    bit in_reset   = 1'b1;
    int h0         = 1000000;
    int hold_start = 0;
    bit snap_valid = 1'b0;
    int rel_t [NUM_CH];
    int next_tick  = 0;
    bit tick_exp   = 1'b0;

    // Observations, relative to H0
    int first_rise [NUM_CH];
    int tick_log [$];

    typedef struct packed {
        logic [NUM_CH*DLY_W-1:0] dly;
        logic [DIV_W-1:0]        div;
        logic [NUM_CH-1:0][15:0] rise;
        logic [15:0]             first_tick;
    } vec_t;

    vec_t vecs [4];
    int   exp_ticks [5] = '{4, 8, 12, 14, 16};
    logic [NUM_CH*DLY_W-1:0] rd;

    // Advance the model by one cycle using the inputs currently applied.
    task automatic model_update();
        int n;
        int t;
        n = cyc;
        if (in_reset) return;
        tick_exp = 1'b0;
        if (n == h0 - 1) begin
            next_tick = h0 + int'(div_i) + 1;
        end else if (n >= h0 && n == next_tick - 1) begin
            tick_exp  = 1'b1;
            next_tick = n + 2 + int'(div_i);
        end
        if (n >= h0) begin
            if (sw_rst_req) begin
                hold_start = n + 1;
                snap_valid = 1'b0;
            end else if (!snap_valid && n == hold_start + MIN_ASSERT - 1) begin
                t = n + 1;
                for (int k = 0; k < NUM_CH; k++) begin
                    t = t + int'(ch_dly_i[k*DLY_W +: DLY_W]) + 1;
                    rel_t[k] = t;
                end
                snap_valid = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [NUM_CH-1:0] e_ch;
        logic e_done, e_busy, e_tick;
        e_ch = '0; e_done = 1'b0; e_busy = 1'b1; e_tick = 1'b0;
        if (!in_reset && cyc >= h0) begin
            for (int k = 0; k < NUM_CH; k++) e_ch[k] = snap_valid && (cyc >= rel_t[k]);
            e_done = snap_valid && (cyc >= rel_t[NUM_CH-1]);
            e_busy = !e_done;
            e_tick = tick_exp;
        end
        vec_cnt++;
        if ({ch_rst_n_o, seq_done_o, busy_o, tick_o} !== {e_ch, e_done, e_busy, e_tick}) begin
            err_cnt++;
            $display("FAIL cycle_model cyc=%0d H%0d got ch=%b done=%b busy=%b tick=%b want ch=%b done=%b busy=%b tick=%b",
                     cyc, cyc - h0, ch_rst_n_o, seq_done_o, busy_o, tick_o, e_ch, e_done, e_busy, e_tick);
        end
        if (!in_reset && cyc >= h0) begin
            for (int k = 0; k < NUM_CH; k++)
                if (ch_rst_n_o[k] === 1'b1 && first_rise[k] < 0) first_rise[k] = cyc - h0;
            if (tick_o === 1'b1) tick_log.push_back(cyc - h0);
        end
    endtask

    task automatic step();
        model_update();
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic run_to(input int h);
        while (cyc < h0 + h) step();
    endtask

    task automatic clear_rise();
        for (int k = 0; k < NUM_CH; k++) first_rise[k] = -1;
    endtask

    // Drops reset between edges, checks the outputs clear with no edge,
    // then releases reset on a falling edge and re-arms the model.
    task automatic apply_reset(input logic [NUM_CH*DLY_W-1:0] dly, input logic [DIV_W-1:0] dv);
        #2;
        reset      = 1'b0;
        in_reset   = 1'b1;
        snap_valid = 1'b0;
        tick_exp   = 1'b0;
        #1;
        vec_cnt++;
        if ({ch_rst_n_o, seq_done_o, busy_o, tick_o} !== {{NUM_CH{1'b0}}, 1'b0, 1'b1, 1'b0}) begin
            err_cnt++;
            $display("FAIL async_reset got ch=%b done=%b busy=%b tick=%b want ch=0 done=0 busy=1 tick=0",
                     ch_rst_n_o, seq_done_o, busy_o, tick_o);
        end
        ch_dly_i   = dly;
        div_i      = dv;
        sw_rst_req = 1'b0;
        repeat (3) step();
        reset      = 1'b1;
        in_reset   = 1'b0;
        h0         = cyc + SYNC_STAGES;
        hold_start = h0;
        clear_rise();
        tick_log.delete();
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        vec_cnt++;
        if (got != want) begin
            err_cnt++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ft;
        int cnt;

        // {dly, div, rise ch3..ch0 (H index), first tick (H index)}
        vecs[0] = {T1_DLY, 8'd3, 16'd28, 16'd26, 16'd20, 16'd19, 16'd4};
        vecs[1] = {32'h0000_0000, 8'd0, 16'd20, 16'd19, 16'd18, 16'd17, 16'd1};
        vecs[2] = {32'hFF00_0000, 8'd1, 16'd275, 16'd19, 16'd18, 16'd17, 16'd2};
        vecs[3] = {32'h0303_0303, 8'd7, 16'd32, 16'd28, 16'd24, 16'd20, 16'd8};

        // Table vectors: full power-on sequence, release cycles and first tick
        for (int v = 0; v < 4; v++) begin
            apply_reset(vecs[v].dly, vecs[v].div);
            while (seq_done_o !== 1'b1 && cyc < h0 + 400) step();
            step();
            for (int k = 0; k < NUM_CH; k++)
                expect_int($sformatf("tbl%0d_ch%0d_rise", v, k), first_rise[k], int'(vecs[v].rise[k]));
            ft = (tick_log.size() > 0) ? tick_log[0] : -1;
            expect_int($sformatf("tbl%0d_first_tick", v), ft, int'(vecs[v].first_tick));
            $display("vector %0d: dly=%h div=%0d rises H%0d/H%0d/H%0d/H%0d", v, vecs[v].dly, vecs[v].div,
                     first_rise[0], first_rise[1], first_rise[2], first_rise[3]);
        end

        // Soft-reset pulse at H22 during the test-1 sequence
        apply_reset(T1_DLY, 8'd3);
        run_to(22);
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        expect_int("sw_clear_ch", int'(ch_rst_n_o), 0);
        expect_int("sw_clear_busy", int'(busy_o), 1);
        clear_rise();
        while (first_rise[0] < 0 && cyc < h0 + 100) step();
        expect_int("sw_ch0_rerise", first_rise[0], 42);
        $display("sw pulse at H22: ch0 rises again at H%0d", first_rise[0]);

        // Async reset while in DONE, then a complete restart
        while (seq_done_o !== 1'b1 && cyc < h0 + 200) step();
        expect_int("reached_done", int'(seq_done_o), 1);
        apply_reset(T1_DLY, 8'd3);
        while (first_rise[NUM_CH-1] < 0 && cyc < h0 + 100) step();
        expect_int("restart_ch0_rise", first_rise[0], 19);
        expect_int("restart_ch3_rise", first_rise[NUM_CH-1], 28);
        $display("reset in DONE: restart ch0 H%0d ch3 H%0d", first_rise[0], first_rise[NUM_CH-1]);

        // Tick: period 4, switch to period 2 mid-period, then continuous
        apply_reset('0, 8'd3);
        run_to(9);
        div_i = 8'd1;
        run_to(17);
        for (int i = 0; i < 5; i++)
            expect_int($sformatf("tick_seq_%0d", i), (i < tick_log.size()) ? tick_log[i] : -1, exp_ticks[i]);
        div_i = 8'd0;
        run_to(31);
        cnt = 0;
        foreach (tick_log[i]) if (tick_log[i] >= 19 && tick_log[i] <= 30) cnt++;
        expect_int("tick_continuous", cnt, 12);
        $display("tick test: %0d ticks logged, %0d in H19..H30", tick_log.size(), cnt);

        // Gap rewrite during RELEASE only affects the next sequence
        apply_reset(T1_DLY, 8'd3);
        run_to(20);
        ch_dly_i = MAX_DLY;
        while (seq_done_o !== 1'b1 && cyc < h0 + 100) step();
        expect_int("rewrite_ch0", first_rise[0], 19);
        expect_int("rewrite_ch2", first_rise[2], 26);
        expect_int("rewrite_ch3", first_rise[3], 28);
        run_to(30);
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        clear_rise();
        while (first_rise[0] < 0 && cyc < h0 + 400) step();
        expect_int("rewrite_next_ch0", first_rise[0], 303);
        $display("gap rewrite: next sequence ch0 at H%0d", first_rise[0]);

        // Randomised rounds against the timeline model
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NUM_CH; k++) rd[k*DLY_W +: DLY_W] = DLY_W'($urandom_range(0, 12));
            apply_reset(rd, DIV_W'($urandom_range(0, 5)));
            for (int c = 0; c < 180; c++) begin
                sw_rst_req = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 29) == 0) div_i = DIV_W'($urandom_range(0, 6));
                if ($urandom_range(0, 39) == 0) begin
                    for (int k = 0; k < NUM_CH; k++) rd[k*DLY_W +: DLY_W] = DLY_W'($urandom_range(0, 12));
                    ch_dly_i = rd;
                end
                step();
            end
            sw_rst_req = 1'b0;
            $display("random round %0d: cyc=%0d miscompares so far %0d", r, cyc, err_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/rst_seq_gen.md
# rst_seq_gen

Parametrised reset sequencer and clock-enable generator; the synthesizable successor to a single fixed-delay bench reset pulse. Takes one board reset and releases NUM_CH downstream block resets in a fixed order, with programmable per-channel gaps, a soft-reset request, and a programmable-rate tick. Sits between the top-level clock/reset source and DUT sub-blocks, one per clock domain.

## Interface
- NUM_CH, 4: number of sequenced reset channels (1..16)
- DLY_W, 8: width of each per-channel release gap
- MIN_ASSERT, 16: cycles all channels stay held after any reset source clears (≥1)
- SYNC_STAGES, 2: reset-deassert synchroniser depth (≥2)
- DIV_W, 8: tick divider width

- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low: assertion takes effect immediately, deassertion synchronised internally
- sw_rst_req  in  1  synchronous soft-reset request, level-sensitive
- ch_dly_i  in  NUM_CH*DLY_W  gap before channel k release, slice [k*DLY_W +: DLY_W]
- div_i  in  DIV_W  tick period minus one
- ch_rst_n_o  out  NUM_CH  active-low channel resets, bit k = channel k
- seq_done_o  out  1  all channels released
- busy_o  out  1  sequence not complete
- tick_o  out  1  single-cycle clock enable

## Operation
- Reset values (reset low): ch_rst_n_o=0, seq_done_o=0, busy_o=1, tick_o=0; FSM=HOLD, counters=0. Applied asynchronously, with no clock edge needed.
- rst_sync_n: reset passed through SYNC_STAGES flops (async clear, D=1). All logic below is held in its reset state while rst_sync_n=0.
- FSM states: HOLD, RELEASE, DONE.
  - HOLD: cnt counts 0..MIN_ASSERT-1, then go to RELEASE with idx=0, cnt=0. On entry to RELEASE, snapshot all of ch_dly_i into dly_q.
  - RELEASE: cnt counts up. When cnt==dly_q[idx], drive ch_rst_n_o[idx]=1 and clear cnt. If idx==NUM_CH-1, go to DONE; otherwise increment idx.
  - DONE: seq_done_o=1, busy_o=0. Stays in DONE until a reset source occurs.
- Channel k releases exactly dly_q[k]+1 cycles after channel k-1 released (for channel 0, after RELEASE entry). Released channels stay high; channels release in order 0..NUM_CH-1 only.
- sw_rst_req=1 sampled in any state: on the next edge, all ch_rst_n_o=0, seq_done_o=0, busy_o=1, FSM=HOLD, cnt=0. While sw_rst_req is held high, HOLD cnt stays 0. Counting starts on the first cycle after it drops.
- Simultaneous events: sw_rst_req beats a pending channel release or DONE entry in the same cycle. reset beats everything.
- ch_dly_i changes during RELEASE have no effect until the next sequence.
- Tick: tcnt counts 0..div_q, where div_q = div_i, sampled at reset exit and at every wrap. tick_o=1 in the cycle tcnt==div_q, and tcnt then wraps to 0. With div_i=0, tick_o is high every cycle. The tick runs independently of the FSM and of sw_rst_req, and is stopped only by reset.

## Timing
- Let H0 be the first cycle with rst_sync_n=1. H0 comes SYNC_STAGES rising edges after reset deasserts.
- FSM is in HOLD for H0..H(MIN_ASSERT-1) and enters RELEASE at H(MIN_ASSERT).
- All outputs are registered; there are no combinational input-to-output paths.
- seq_done_o and busy_o change in the same cycle as the last channel release.
- Counter widths: cnt uses max(DLY_W, clog2(MIN_ASSERT)) bits, with no overflow because compare-and-clear always happens first. idx uses clog2(NUM_CH) bits (minimum 1).

## Structure
- Package rst_seq_pkg holds:
  - typedef enum logic [1:0] {HOLD, RELEASE, DONE} seq_state_e
  - a localparam function for the cnt width
- Sub-module rst_sync (parameter STAGES) provides async-assert/sync-deassert. It is reusable by other blocks.

## Test plan
Defaults apply (NUM_CH=4, MIN_ASSERT=16, SYNC_STAGES=2).

1. Power-on, ch_dly_i={ch3=1, ch2=5, ch1=0, ch0=2} -> ch0 rises at H19, ch1 at H20, ch2 at H26, ch3 at H28. seq_done_o=1 and busy_o=0 from H28.
2. All delays 0 -> ch0..ch3 rise at H17, H18, H19, H20; seq_done_o rises at H20.
3. One-cycle sw_rst_req pulse sampled at H22 during test 1 -> all ch_rst_n_o=0 at H23. HOLD restarts; ch0 next rises 16+3 cycles after H23.
4. reset driven low between edges while in DONE -> ch_rst_n_o=0, seq_done_o=0, tick_o=0 immediately, with no edge needed. After reset rises, the full sequence restarts from a new H0.
5. div_i=3 -> tick_o high every 4th cycle. div_i=0 -> tick_o high continuously. Changing div_i from 3 to 1 mid-period -> the old period finishes first, then the period is 2.
6. Rewrite ch_dly_i to all 255 at H20 during test 1 -> release times unchanged from test 1. The next sequence after sw_rst_req uses 256-cycle gaps.
